// File: rtl/load_store_unit.sv
// Load/store stage: one req/ack data-bus transaction per accepted access, with
// byte-lane steering, alignment/illegal checks, load extension and bus timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        data_r,
  input  logic        data_w,
  input  logic [1:0]  data_size,
  input  logic        unsigned_value,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         off_q, off_d;
  logic               uns_q, uns_d;
  logic               done_d, fault_d, mem_req_d, mem_we_d;
  logic [1:0]         cause_d;
  logic [31:0]        rd_d, mem_addr_d, mem_wdata_d;
  logic [3:0]         wstrb_d;

  logic [7:0]         lb;
  logic [15:0]        lh;
  logic [31:0]        load_ext;
  logic [3:0]         wstrb_s;
  logic [31:0]        wdata_s;
  logic               illegal, misaligned;

  assign busy = (state_q != IDLE);

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    lb = 8'h00;
    case (off_q)
      2'd0:    lb = mem_rdata[7:0];
      2'd1:    lb = mem_rdata[15:8];
      2'd2:    lb = mem_rdata[23:16];
      default: lb = mem_rdata[31:24];
    endcase
    lh = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, lb} : {{24{lb[7]}}, lb};
      2'b01:   load_ext = uns_q ? {16'h0, lh} : {{16{lh[15]}}, lh};
      default: load_ext = mem_rdata;
    endcase
  end

  // Request decode: lane steering and fault classification of the issuing access.
  always_comb begin
    wstrb_s = 4'b1111;
    wdata_s = wdata;
    case (data_size)
      2'b00: begin
        wstrb_s = 4'b0001 << addr[1:0];
        wdata_s = {4{wdata[7:0]}};
      end
      2'b01: begin
        wstrb_s = 4'b0011 << addr[1:0];
        wdata_s = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    illegal    = (data_r && data_w) || (data_size == 2'b11);
    misaligned = ((data_size == 2'b01) && addr[0]) ||
                 ((data_size == 2'b10) && (addr[1:0] != 2'b00));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    cause_d     = fault_cause;
    rd_d        = rd_data;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    wstrb_d     = mem_wstrb;

    case (state_q)
      IDLE: begin
        if (start && (data_r || data_w)) begin
          size_d = data_size;
          off_d  = addr[1:0];
          uns_d  = unsigned_value;
          cnt_d  = '0;
          if (illegal) begin
            state_d = FAULT;
            fault_d = 1'b1;
            cause_d = 2'b11;
          end else if (misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
            cause_d = 2'b01;
          end else begin
            state_d     = REQ;
            cause_d     = 2'b00;
            mem_req_d   = 1'b1;
            mem_we_d    = data_w;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = wdata_s;
            wstrb_d     = data_w ? wstrb_s : 4'b0000;
          end
        end
      end
      REQ: begin
        // An ack in the final counted cycle takes priority over the timeout.
        if (mem_ack) begin
          if (!mem_we) rd_d = load_ext;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          cause_d   = 2'b10;
          state_d   = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      rd_data     <= 32'h0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_wstrb   <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      done        <= done_d;
      fault       <= fault_d;
      fault_cause <= cause_d;
      rd_data     <= rd_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      mem_wstrb   <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_load_store_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        data_r = 1'b0;
  logic        data_w = 1'b0;
  logic [1:0]  data_size = 2'b00;
  logic        unsigned_value = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        busy, done, fault, mem_req, mem_we;
  logic [31:0] rd_data, mem_addr, mem_wdata;
  logic [1:0]  fault_cause;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_fail = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_r(data_r), .data_w(data_w),
    .data_size(data_size), .unsigned_value(unsigned_value), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rd_data(rd_data), .fault(fault),
    .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Extend a lane of the read word using plain modular arithmetic.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic [1:0] off, input logic uns);
    logic [31:0] md, v;
    if (size == 2'b10) return raw;
    md = (size == 2'b00) ? 32'd256 : 32'd65536;
    v  = (raw >> (8 * off)) % md;
    if (!uns && (v >= md / 2)) v = v - md;
    return v;
  endfunction

  // Model: expected outputs for the cycle following each rising edge.
  logic        m_req = 0, m_busy = 0, m_done = 0, m_fault = 0, m_we = 0, m_load = 0, m_uns = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rd = 0;
  logic [3:0]  m_wstrb = 0;
  logic [1:0]  m_cause = 0, m_size = 0, m_off = 0;
  int unsigned m_waited = 0;
  bit          seen_reset = 0;

  always @(posedge clk) begin
    int unsigned nb;
    if (!rst_n) begin
      m_req = 0; m_busy = 0; m_done = 0; m_fault = 0; m_we = 0; m_rd = 0;
      m_addr = 0; m_wdata = 0; m_wstrb = 0; m_cause = 0; m_waited = 0;
      seen_reset = 1;
    end else if (m_done || m_fault) begin
      m_done = 0; m_fault = 0; m_busy = 0;
    end else if (m_req) begin
      if (mem_ack) begin
        if (m_load) m_rd = extend(mem_rdata, m_size, m_off, m_uns);
        m_req = 0; m_done = 1;
      end else begin
        m_waited++;
        if (TO != 0 && m_waited == TO) begin
          m_req = 0; m_fault = 1; m_cause = 2'b10;
        end
      end
    end else if (start && (data_r || data_w)) begin
      nb = (data_size == 2'b00) ? 1 : (data_size == 2'b01) ? 2 : 4;
      m_busy = 1;
      if ((data_r && data_w) || data_size == 2'b11) begin
        m_fault = 1; m_cause = 2'b11;
      end else if (addr % nb != 0) begin
        m_fault = 1; m_cause = 2'b01;
      end else begin
        m_req = 1; m_waited = 0; m_load = data_r; m_we = data_w;
        m_size = data_size; m_off = addr[1:0]; m_uns = unsigned_value;
        m_addr = addr - (addr % 4);
        m_wstrb = data_w ? 4'(((1 << nb) - 1) << (addr % 4)) : 4'b0000;
        m_wdata = (nb == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
                  (nb == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
      end
    end
  end

  // Compare DUT against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (seen_reset) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("mem_req", 32'(mem_req), 32'(m_req));
      chk("done", 32'(done), 32'(m_done));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("rd_data", rd_data, m_rd);
      if (m_req) begin
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_fault) chk("fault_cause", 32'(fault_cause), 32'(m_cause));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    start = 1; data_r = r; data_w = w; data_size = sz; unsigned_value = u; addr = a; wdata = wd;
    tick();
    start = 0; data_r = 0; data_w = 0;
  endtask

  // Called during cycle 1 of a request; acks in cycle k, returns in cycle k+1.
  task automatic ack_in(input int k, input logic [31:0] rd);
    repeat (k - 1) tick();
    mem_ack = 1; mem_rdata = rd;
    tick();
    mem_ack = 0; mem_rdata = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_done_fault", 32'({done, fault}), 32'h0);
    chk("rst_rd", rd_data, 32'h0);
    chk("rst_cause", 32'(fault_cause), 32'h0);
    rst_n = 1;
    tick();

    // LB / LBU at 0x1003, ack after 2 wait cycles
    issue(1, 0, 2'b00, 0, 32'h1003, 0);
    @(negedge clk);
    chk("t1_addr", mem_addr, 32'h00001000);
    chk("t1_wstrb", 32'(mem_wstrb), 32'h0);
    ack_in(3, 32'h80AABBCC);
    @(negedge clk);
    chk("t1_done_c4", 32'(done), 32'h1);
    chk("t1_lb", rd_data, 32'hFFFFFF80);
    tick();
    issue(1, 0, 2'b00, 1, 32'h1003, 0);
    ack_in(3, 32'h80AABBCC);
    @(negedge clk);
    chk("t1_lbu", rd_data, 32'h00000080);
    tick();

    // SH at 0x2002
    issue(0, 1, 2'b01, 0, 32'h2002, 32'h1234ABCD);
    @(negedge clk);
    chk("t2_we", 32'(mem_we), 32'h1);
    chk("t2_wstrb", 32'(mem_wstrb), 32'hC);
    chk("t2_wdata", mem_wdata, 32'hABCDABCD);
    ack_in(1, 32'h0);
    @(negedge clk);
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_rd_held", rd_data, 32'h00000080);
    tick();

    // Misaligned LW / LH, then aligned LH
    issue(1, 0, 2'b10, 0, 32'h6, 0);
    @(negedge clk);
    chk("t3_lw_fault", 32'({fault, mem_req}), 32'h2);
    chk("t3_lw_cause", 32'(fault_cause), 32'h1);
    tick();
    @(negedge clk);
    chk("t3_idle", 32'(busy), 32'h0);
    issue(1, 0, 2'b01, 0, 32'h5, 0);
    @(negedge clk);
    chk("t3_lh_fault", 32'({fault, mem_req}), 32'h2);
    chk("t3_lh_cause", 32'(fault_cause), 32'h1);
    tick();
    issue(1, 0, 2'b01, 0, 32'h6, 0);
    ack_in(1, 32'h7FFF0000);
    @(negedge clk);
    chk("t3_lh_rd", rd_data, 32'h00007FFF);
    tick();

    // SW timeout, then ack on the final cycle
    issue(0, 1, 2'b10, 0, 32'h100, 32'hCAFEF00D);
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      if (fault) seen = 1;
    end
    chk("t4_req_cycles", 32'(cnt), 32'd16);
    chk("t4_fault_seen", 32'(seen), 32'h1);
    chk("t4_cause", 32'(fault_cause), 32'h2);
    tick();
    issue(0, 1, 2'b10, 0, 32'h100, 32'hCAFEF00D);
    ack_in(16, 32'h0);
    @(negedge clk);
    chk("t4_ack_wins", 32'({done, fault}), 32'h2);
    tick();

    // Illegal accesses and start while busy
    issue(1, 1, 2'b10, 0, 32'h40, 0);
    @(negedge clk);
    chk("t5_rw_cause", 32'(fault_cause), 32'h3);
    tick();
    issue(1, 0, 2'b11, 0, 32'h40, 0);
    @(negedge clk);
    chk("t5_size_cause", 32'(fault_cause), 32'h3);
    tick();
    issue(1, 0, 2'b10, 0, 32'h20, 0);
    start = 1; data_w = 1; data_size = 2'b10; addr = 32'h44; wdata = 32'h55;
    cnt = 0;
    @(negedge clk); cnt += int'(mem_req);
    tick();
    @(negedge clk); cnt += int'(mem_req);
    chk("t5_addr_held", mem_addr, 32'h00000020);
    tick();
    start = 0; data_w = 0;
    mem_ack = 1; mem_rdata = 32'h11223344;
    @(negedge clk); cnt += int'(mem_req);
    tick();
    mem_ack = 0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("t5_done_rd", rd_data, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk); cnt += int'(mem_req);
    end
    chk("t5_one_request", 32'(cnt), 32'd3);
    tick();

    // Reset during REQ, then a normal LW
    issue(1, 0, 2'b10, 0, 32'h30, 0);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("t6_abort", 32'({busy, mem_req, done, fault}), 32'h0);
    tick();
    issue(1, 0, 2'b10, 0, 32'h10, 0);
    ack_in(1, 32'hDEADBEEF);
    @(negedge clk);
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_rd", rd_data, 32'hDEADBEEF);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
